// File: rtl/udt_handshake_tx_if.sv
// udt_handshake_tx_if
// AXI-stream carrying the UDT handshake packet from the transmitter to the
// packet output mux.
//   req_tdata  : 64-bit beat, byte 0 in [63:56]
//   req_tkeep  : byte enables, all ones while valid
//   req_tvalid : beat valid
//   req_tlast  : final beat (beat 7) of the packet
//   req_tready : downstream ready
interface udt_handshake_tx_if ();
  logic [63:0] req_tdata;
  logic [7:0]  req_tkeep;
  logic        req_tvalid;
  logic        req_tlast;
  logic        req_tready;

  modport master (
    output req_tdata,
    output req_tkeep,
    output req_tvalid,
    output req_tlast,
    input  req_tready
  );

  modport slave (
    input  req_tdata,
    input  req_tkeep,
    input  req_tvalid,
    input  req_tlast,
    output req_tready
  );
endinterface

// File: rtl/udt_handshake_tx.sv
// udt_handshake_tx
// Builds one 64-byte UDT handshake control packet from connection parameters
// latched at request acceptance and emits it as eight 64-bit stream beats.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   Tx_Req / Tx_Ready : send request, accepted while Tx_Ready is high
//   Tx_Done           : one-cycle pulse after the last beat transfers
//   Tx_Count          : wrapping count of packets sent
//   Conn_Type .. Peer_IP : handshake field values
//   req               : outgoing AXI-stream (master side)
module udt_handshake_tx #(
  parameter logic [31:0] VERSION   = 32'd4,
  parameter logic [31:0] SOCK_TYPE = 32'd1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Tx_Req,
  output logic                      Tx_Ready,
  output logic                      Tx_Done,
  output logic [15:0]               Tx_Count,
  input  logic [31:0]               Conn_Type,
  input  logic [31:0]               INIT_SEQ,
  input  logic [31:0]               MSSize,
  input  logic [31:0]               FlightFlagSize,
  input  logic [31:0]               Socket_ID,
  input  logic [31:0]               Dst_Socket_ID,
  input  logic [31:0]               SYN_Cookie,
  input  logic [31:0]               Timestamp,
  input  logic [127:0]              Peer_IP,
  udt_handshake_tx_if.master        req
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t       r_state;
  logic [2:0]   r_beat;
  logic [63:0]  r_tdata;
  logic [7:0]   r_tkeep;
  logic         r_tvalid;
  logic         r_tlast;
  logic         r_tx_ready;
  logic         r_tx_done;
  logic [15:0]  r_tx_count;

  // Shadow copy of the fields, frozen for the packet in flight
  logic [31:0]  r_sh_conn_type;
  logic [31:0]  r_sh_init_seq;
  logic [31:0]  r_sh_mss;
  logic [31:0]  r_sh_flight;
  logic [31:0]  r_sh_sock_id;
  logic [31:0]  r_sh_dst_id;
  logic [31:0]  r_sh_cookie;
  logic [31:0]  r_sh_tstamp;
  logic [127:0] r_sh_peer_ip;

  state_t       w_state_nx;
  logic [2:0]   w_beat_nx;
  logic [2:0]   w_beat_inc;
  logic [63:0]  w_tdata_nx;
  logic [7:0]   w_tkeep_nx;
  logic         w_tvalid_nx;
  logic         w_tlast_nx;
  logic         w_ready_nx;
  logic         w_done_nx;
  logic [15:0]  w_count_nx;
  logic         w_latch;
  logic [63:0]  w_words [8];

  assign w_beat_inc = r_beat + 3'd1;

  // Packet words assembled from the shadow registers
  always_comb begin
    w_words[0] = {32'h8000_0000, 32'h0000_0000};
    w_words[1] = {r_sh_tstamp, r_sh_dst_id};
    w_words[2] = {VERSION, SOCK_TYPE};
    w_words[3] = {r_sh_init_seq, r_sh_mss};
    w_words[4] = {r_sh_flight, r_sh_conn_type};
    w_words[5] = {r_sh_sock_id, r_sh_cookie};
    w_words[6] = r_sh_peer_ip[127:64];
    w_words[7] = r_sh_peer_ip[63:0];
  end

  // Next-state and next-output logic; outputs are then registered
  always_comb begin
    w_state_nx  = r_state;
    w_beat_nx   = r_beat;
    w_tdata_nx  = r_tdata;
    w_tkeep_nx  = r_tkeep;
    w_tvalid_nx = r_tvalid;
    w_tlast_nx  = r_tlast;
    w_ready_nx  = r_tx_ready;
    w_done_nx   = 1'b0;
    w_count_nx  = r_tx_count;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Tx_Req) begin
          // Beat 0 is field-independent, so it can be loaded while the
          // shadow registers capture the fields on the same edge.
          w_state_nx  = ST_SEND;
          w_beat_nx   = 3'd0;
          w_tdata_nx  = {32'h8000_0000, 32'h0000_0000};
          w_tkeep_nx  = 8'hFF;
          w_tvalid_nx = 1'b1;
          w_tlast_nx  = 1'b0;
          w_ready_nx  = 1'b0;
          w_latch     = 1'b1;
        end else begin
          w_tvalid_nx = 1'b0;
          w_tlast_nx  = 1'b0;
          w_ready_nx  = 1'b1;
        end
      end
      ST_SEND: begin
        if (r_tvalid && req.req_tready) begin
          if (r_beat == 3'd7) begin
            w_state_nx  = ST_IDLE;
            w_beat_nx   = 3'd0;
            w_tdata_nx  = 64'h0;
            w_tkeep_nx  = 8'h00;
            w_tvalid_nx = 1'b0;
            w_tlast_nx  = 1'b0;
            w_ready_nx  = 1'b1;
            w_done_nx   = 1'b1;
            w_count_nx  = r_tx_count + 16'd1;
          end else begin
            w_beat_nx   = w_beat_inc;
            w_tdata_nx  = w_words[w_beat_inc];
            w_tlast_nx  = (w_beat_inc == 3'd7);
          end
        end else begin
          // Stall: every stream output holds its value
          w_beat_nx   = r_beat;
        end
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_beat_nx   = 3'd0;
        w_tdata_nx  = 64'h0;
        w_tkeep_nx  = 8'h00;
        w_tvalid_nx = 1'b0;
        w_tlast_nx  = 1'b0;
        w_ready_nx  = 1'b1;
      end
    endcase
  end

  // State, beat counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= 3'd0;
      r_tdata    <= 64'h0;
      r_tkeep    <= 8'h00;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_count <= 16'd0;
    end else begin
      r_state    <= w_state_nx;
      r_beat     <= w_beat_nx;
      r_tdata    <= w_tdata_nx;
      r_tkeep    <= w_tkeep_nx;
      r_tvalid   <= w_tvalid_nx;
      r_tlast    <= w_tlast_nx;
      r_tx_ready <= w_ready_nx;
      r_tx_done  <= w_done_nx;
      r_tx_count <= w_count_nx;
    end
  end

  // Field capture on request acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_conn_type <= 32'h0;
      r_sh_init_seq  <= 32'h0;
      r_sh_mss       <= 32'h0;
      r_sh_flight    <= 32'h0;
      r_sh_sock_id   <= 32'h0;
      r_sh_dst_id    <= 32'h0;
      r_sh_cookie    <= 32'h0;
      r_sh_tstamp    <= 32'h0;
      r_sh_peer_ip   <= 128'h0;
    end else if (w_latch) begin
      r_sh_conn_type <= Conn_Type;
      // The sequence number is 31 bits on the wire; bit 31 is cleared here
      r_sh_init_seq  <= INIT_SEQ & 32'h7FFF_FFFF;
      r_sh_mss       <= MSSize;
      r_sh_flight    <= FlightFlagSize;
      r_sh_sock_id   <= Socket_ID;
      r_sh_dst_id    <= Dst_Socket_ID;
      r_sh_cookie    <= SYN_Cookie;
      r_sh_tstamp    <= Timestamp;
      r_sh_peer_ip   <= Peer_IP;
    end else begin
      r_sh_conn_type <= r_sh_conn_type;
      r_sh_init_seq  <= r_sh_init_seq;
      r_sh_mss       <= r_sh_mss;
      r_sh_flight    <= r_sh_flight;
      r_sh_sock_id   <= r_sh_sock_id;
      r_sh_dst_id    <= r_sh_dst_id;
      r_sh_cookie    <= r_sh_cookie;
      r_sh_tstamp    <= r_sh_tstamp;
      r_sh_peer_ip   <= r_sh_peer_ip;
    end
  end

  assign Tx_Ready       = r_tx_ready;
  assign Tx_Done        = r_tx_done;
  assign Tx_Count       = r_tx_count;
  assign req.req_tdata  = r_tdata;
  assign req.req_tkeep  = r_tkeep;
  assign req.req_tvalid = r_tvalid;
  assign req.req_tlast  = r_tlast;

endmodule

// File: tb/tb_udt_handshake_tx.sv
// tb_udt_handshake_tx
// Directed sequence of packets with randomized field values and randomized
// backpressure; expected beats come from a packet model built directly from
// the handshake field layout.
module tb_udt_handshake_tx;

  typedef struct packed {
    logic [31:0]  conn_type;
    logic [31:0]  init_seq;
    logic [31:0]  mss;
    logic [31:0]  flight;
    logic [31:0]  sock_id;
    logic [31:0]  dst_id;
    logic [31:0]  cookie;
    logic [31:0]  tstamp;
    logic [127:0] peer_ip;
  } pkt_t;

  logic         clk;
  logic         rst_n;
  logic         Tx_Req;
  logic         Tx_Ready;
  logic         Tx_Done;
  logic [15:0]  Tx_Count;
  logic [31:0]  Conn_Type, INIT_SEQ, MSSize, FlightFlagSize;
  logic [31:0]  Socket_ID, Dst_Socket_ID, SYN_Cookie, Timestamp;
  logic [127:0] Peer_IP;

  int n_cmp;
  int n_err;
  int exp_count;

  udt_handshake_tx_if ifc ();

  udt_handshake_tx #(.VERSION(32'd4), .SOCK_TYPE(32'd1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Tx_Req         (Tx_Req),
    .Tx_Ready       (Tx_Ready),
    .Tx_Done        (Tx_Done),
    .Tx_Count       (Tx_Count),
    .Conn_Type      (Conn_Type),
    .INIT_SEQ       (INIT_SEQ),
    .MSSize         (MSSize),
    .FlightFlagSize (FlightFlagSize),
    .Socket_ID      (Socket_ID),
    .Dst_Socket_ID  (Dst_Socket_ID),
    .SYN_Cookie     (SYN_Cookie),
    .Timestamp      (Timestamp),
    .Peer_IP        (Peer_IP),
    .req            (ifc.master)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake packet as eight big-endian 64-bit words
  function automatic logic [7:0][63:0] model_words(input pkt_t p);
    logic [7:0][63:0] w;
    logic [31:0] seq;
    seq  = p.init_seq;
    seq[31] = 1'b0;
    w[0] = {32'h8000_0000, 32'h0000_0000};
    w[1] = {p.tstamp, p.dst_id};
    w[2] = {32'd4, 32'd1};
    w[3] = {seq, p.mss};
    w[4] = {p.flight, p.conn_type};
    w[5] = {p.sock_id, p.cookie};
    w[6] = p.peer_ip[127:64];
    w[7] = p.peer_ip[63:0];
    return w;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.conn_type = ($urandom_range(1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
    p.init_seq  = $urandom;
    p.mss       = $urandom;
    p.flight    = $urandom;
    p.sock_id   = $urandom;
    p.dst_id    = $urandom;
    p.cookie    = $urandom;
    p.tstamp    = $urandom;
    p.peer_ip   = {$urandom, $urandom, $urandom, $urandom};
    return p;
  endfunction

  task automatic apply(input pkt_t p);
    Conn_Type      = p.conn_type;
    INIT_SEQ       = p.init_seq;
    MSSize         = p.mss;
    FlightFlagSize = p.flight;
    Socket_ID      = p.sock_id;
    Dst_Socket_ID  = p.dst_id;
    SYN_Cookie     = p.cookie;
    Timestamp      = p.tstamp;
    Peer_IP        = p.peer_ip;
  endtask

  // Request one packet and check every beat. stall_pct: chance of tready low;
  // chg: scramble inputs after acceptance; hold: keep Tx_Req high;
  // abort_at: beat index at which reset is applied (-1 = none).
  task automatic do_packet(input pkt_t p, input int stall_pct, input bit chg,
                           input bit hold, input int abort_at);
    logic [7:0][63:0] exp_w;
    logic rdy;
    int idx;
    int cyc;
    exp_w = model_words(p);
    apply(p);
    Tx_Req = 1'b1;
    chk("ready_before_req", Tx_Ready, 1);
    chk("tvalid_before_req", ifc.req_tvalid, 0);
    tick();
    if (!hold) Tx_Req = 1'b0;
    if (chg) apply(rand_pkt());
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 400) begin
      if (abort_at >= 0 && idx == abort_at) begin
        ifc.req_tready = 1'b0;
        tick();
        chk("stall_tdata", ifc.req_tdata, exp_w[idx]);
        tick();
        chk("stall_tvalid", ifc.req_tvalid, 1);
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("rst_tvalid", ifc.req_tvalid, 0);
        chk("rst_tdata", ifc.req_tdata, 0);
        chk("rst_tkeep", ifc.req_tkeep, 0);
        chk("rst_tlast", ifc.req_tlast, 0);
        chk("rst_ready", Tx_Ready, 1);
        chk("rst_count", Tx_Count, 0);
        tick();
        rst_n = 1'b1;
        Tx_Req = 1'b0;
        tick();
        chk("post_rst_tvalid", ifc.req_tvalid, 0);
        return;
      end
      rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      ifc.req_tready = rdy;
      chk("tvalid", ifc.req_tvalid, 1);
      chk($sformatf("tdata_b%0d", idx), ifc.req_tdata, exp_w[idx]);
      chk("tkeep", ifc.req_tkeep, 8'hFF);
      chk("tlast", ifc.req_tlast, (idx == 7) ? 1 : 0);
      chk("ready_busy", Tx_Ready, 0);
      chk("done_busy", Tx_Done, 0);
      tick();
      if (rdy) idx++;
      cyc++;
    end
    if (idx != 8) chk("beat_timeout", idx, 8);
    exp_count++;
    chk("done_pulse", Tx_Done, 1);
    chk("tvalid_after", ifc.req_tvalid, 0);
    chk("tlast_after", ifc.req_tlast, 0);
    chk("ready_after", Tx_Ready, 1);
    chk("tx_count", Tx_Count, exp_count[15:0]);
    if (!hold) begin
      tick();
      chk("done_once", Tx_Done, 0);
      chk("idle_tvalid", ifc.req_tvalid, 0);
    end
  endtask

  pkt_t p0;

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_count = 0;
    rst_n = 1'b0;
    Tx_Req = 1'b1;  // request during reset must be ignored
    ifc.req_tready = 1'b1;
    apply('0);

    repeat (10) @(posedge clk);
    #1;
    chk("rst_tvalid", ifc.req_tvalid, 0);
    chk("rst_tlast", ifc.req_tlast, 0);
    chk("rst_tdata", ifc.req_tdata, 0);
    chk("rst_tkeep", ifc.req_tkeep, 0);
    chk("rst_ready", Tx_Ready, 1);
    chk("rst_done", Tx_Done, 0);
    chk("rst_count", Tx_Count, 0);
    Tx_Req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_tvalid", ifc.req_tvalid, 0);
    chk("idle_ready", Tx_Ready, 1);

    // Single packet with the reference field values
    p0.conn_type = 32'd1;
    p0.init_seq  = 32'hFFFF_0001;
    p0.mss       = 32'd8000;
    p0.flight    = 32'd256000;
    p0.sock_id   = 32'h11;
    p0.dst_id    = 32'h0;
    p0.cookie    = 32'hC00C;
    p0.tstamp    = 32'h100;
    p0.peer_ip   = 128'h0A00_0001;
    do_packet(p0, 0, 1'b0, 1'b0, -1);

    // Backpressure at 50%
    do_packet(rand_pkt(), 50, 1'b0, 1'b0, -1);
    do_packet(rand_pkt(), 50, 1'b0, 1'b0, -1);

    // Field inputs changed right after acceptance
    do_packet(rand_pkt(), 0, 1'b1, 1'b0, -1);
    do_packet(rand_pkt(), 40, 1'b1, 1'b0, -1);

    // Back-to-back with Tx_Req held high
    do_packet(rand_pkt(), 0, 1'b0, 1'b1, -1);
    do_packet(rand_pkt(), 0, 1'b0, 1'b1, -1);
    do_packet(rand_pkt(), 0, 1'b0, 1'b1, -1);
    Tx_Req = 1'b0;
    tick();
    chk("b2b_done_low", Tx_Done, 0);
    chk("b2b_idle", ifc.req_tvalid, 0);

    // Reset during a stalled beat 4, then a fresh packet from beat 0
    do_packet(rand_pkt(), 0, 1'b0, 1'b0, 4);
    do_packet(rand_pkt(), 30, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
